// File: rtl/ndo_pulse_driver_if.sv
// Command handshake between a command source and ndo_pulse_driver.
interface ndo_pulse_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_code, output cmd_ready);
endinterface

// File: rtl/ndo_pulse_driver.sv
// Buffers SET/RESET/READ commands and emits them as spaced toggles for the mitll_ndo cell.
// Define NDO_DRV_STATE_AWARE_EN to select spacing from the shadow cell state instead of worst case.
module ndo_pulse_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP0_RS = 1,
  parameter int unsigned GAP1_RS = 2,
  parameter int unsigned GAP1_RC = 2,
  parameter int unsigned GAP1_CR = 3,
  parameter int unsigned GAP1_CC = 5
) (
  input  logic                clk,
  input  logic                reset,
  ndo_pulse_driver_if.slave   cmd,
  output logic                set_t,
  output logic                reset_t,
  output logic                clk_t,
  output logic                shadow_state,
  output logic                busy,
  output logic [7:0]          ev_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] CMD_SET   = 2'b00;
  localparam logic [1:0] CMD_RESET = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  // A gap of G allows the next issue G edges later, so a timer is loaded with G-1.
`ifdef NDO_DRV_STATE_AWARE_EN
  localparam logic [3:0] L0_RS = 4'(GAP0_RS - 1);
  localparam logic [3:0] L1_RS = 4'(GAP1_RS - 1);
`else
  localparam logic [3:0] LW_RS = 4'(((GAP0_RS > GAP1_RS) ? GAP0_RS : GAP1_RS) - 1);
`endif
  localparam logic [3:0] L1_RC = 4'(GAP1_RC - 1);
  localparam logic [3:0] L1_CR = 4'(GAP1_CR - 1);
  localparam logic [3:0] L1_CC = 4'(GAP1_CC - 1);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    t_set_q, t_set_d, t_reset_q, t_reset_d, t_clk_q, t_clk_d;
  logic          set_t_q, set_t_d, reset_t_q, reset_t_d, clk_t_q, clk_t_d;
  logic          shadow_q, shadow_d;
  logic [7:0]    ev_cnt_q, ev_cnt_d;

  logic       full, empty, push, pop, head_ok;
  logic [1:0] head;

  function automatic logic [3:0] tmax(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    push     = cmd.cmd_valid && cmd.cmd_ready;
    head     = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    set_t_d   = set_t_q;
    reset_t_d = reset_t_q;
    clk_t_d   = clk_t_q;
    shadow_d  = shadow_q;
    ev_cnt_d  = ev_cnt_q;
    t_set_d   = (t_set_q   != '0) ? t_set_q   - 4'd1 : '0;
    t_reset_d = (t_reset_q != '0) ? t_reset_q - 4'd1 : '0;
    t_clk_d   = (t_clk_q   != '0) ? t_clk_q   - 4'd1 : '0;

    case (head)
      CMD_SET:   head_ok = (t_set_q   == '0);
      CMD_RESET: head_ok = (t_reset_q == '0);
      CMD_READ:  head_ok = (t_clk_q   == '0);
      default:   head_ok = 1'b1;
    endcase
    pop = !empty && head_ok;

    // Loads merge with the already-decremented value so a pending block is never shortened.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head != 2'b11) ev_cnt_d = ev_cnt_q + 8'd1;
      case (head)
        CMD_SET: begin
          set_t_d  = !set_t_q;
          shadow_d = 1'b1;
`ifndef NDO_DRV_STATE_AWARE_EN
          t_set_d  = tmax(t_set_d, LW_RS);
          t_clk_d  = tmax(t_clk_d, L1_RC);
`endif
        end
        CMD_RESET: begin
          reset_t_d = !reset_t_q;
          shadow_d  = 1'b0;
`ifdef NDO_DRV_STATE_AWARE_EN
          if (shadow_q) begin
            t_set_d = tmax(t_set_d, L1_RS);
            t_clk_d = tmax(t_clk_d, L1_RC);
          end else begin
            t_set_d = tmax(t_set_d, L0_RS);
          end
`else
          t_set_d = tmax(t_set_d, LW_RS);
          t_clk_d = tmax(t_clk_d, L1_RC);
`endif
        end
        CMD_READ: begin
          clk_t_d = !clk_t_q;
`ifdef NDO_DRV_STATE_AWARE_EN
          if (shadow_q) begin
            t_reset_d = tmax(t_reset_d, L1_CR);
            t_clk_d   = tmax(t_clk_d, L1_CC);
          end
`else
          t_reset_d = tmax(t_reset_d, L1_CR);
          t_clk_d   = tmax(t_clk_d, L1_CC);
`endif
        end
        default: ;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = cmd.cmd_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      t_set_q   <= '0;
      t_reset_q <= '0;
      t_clk_q   <= '0;
      set_t_q   <= 1'b0;
      reset_t_q <= 1'b0;
      clk_t_q   <= 1'b0;
      shadow_q  <= 1'b0;
      ev_cnt_q  <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      t_set_q   <= t_set_d;
      t_reset_q <= t_reset_d;
      t_clk_q   <= t_clk_d;
      set_t_q   <= set_t_d;
      reset_t_q <= reset_t_d;
      clk_t_q   <= clk_t_d;
      shadow_q  <= shadow_d;
      ev_cnt_q  <= ev_cnt_d;
    end
    mem_q <= mem_d;
  end

  assign cmd.cmd_ready = reset && !full;
  assign set_t         = set_t_q;
  assign reset_t       = reset_t_q;
  assign clk_t         = clk_t_q;
  assign shadow_state  = shadow_q;
  assign ev_cnt        = ev_cnt_q;
  assign busy          = !empty || (t_set_q != '0) || (t_reset_q != '0) || (t_clk_q != '0);

endmodule

// File: doc/ndo_pulse_driver.md
# ndo_pulse_driver

Clocked command sequencer that sits directly upstream of the NDRO cell model (`mitll_ndo`). It accepts SET / RESET / READ commands over a valid/ready handshake and buffers them in a small FIFO. It emits each command as a toggle (any edge = one pulse) on the cell's `set`, `reset` or `clk` inputs, spacing pulses so the cell's critical-timing windows are never violated. A shadow copy of the cell state selects which spacing rules apply.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- GAP0_RS, 1: state 0, RESET→SET minimum spacing, in cycles (1..15).
- GAP1_RS, 2: state 1, RESET→SET minimum spacing, in cycles.
- GAP1_RC, 2: state 1, RESET→READ minimum spacing, in cycles.
- GAP1_CR, 3: state 1, READ→RESET minimum spacing, in cycles.
- GAP1_CC, 5: state 1, READ→READ minimum spacing, in cycles.
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_code  input  2  00 SET, 01 RESET, 10 READ, 11 NOP.
- cmd_ready  output  1  FIFO can accept.
- set_t  output  1  toggle line to cell `set`.
- reset_t  output  1  toggle line to cell `reset`.
- clk_t  output  1  toggle line to cell `clk`.
- shadow_state  output  1  expected cell state: 0 = cleared, 1 = stored.
- busy  output  1  FIFO non-empty or any spacing timer non-zero.
- ev_cnt  output  8  count of toggles issued; wraps.

## Operation
- Reset (sampled `reset`=0 at a clk edge) sets:
  - all toggle lines, shadow_state, ev_cnt and timers to 0;
  - FIFO to empty;
  - cmd_ready to 0 while reset is asserted, and to 1 on the first cycle after release.
- Accept: a command is written when cmd_valid && cmd_ready. cmd_ready = !full. A same-cycle pop does not free a slot for a same-cycle push.
- Issue engine: the FIFO head is examined every cycle. Commands issue strictly in order, at most one per cycle.
- The head issues when its target timer (t_set, t_reset or t_clk) is zero. On issue:
  - the target toggle line inverts;
  - the entry pops;
  - ev_cnt increments;
  - timers and shadow update as below.
- NOP pops without toggling, without touching timers or shadow, and without incrementing ev_cnt.
- Issue rules, with the `NDO_DRV_STATE_AWARE_EN` macro defined:
  - SET, state 0: shadow → 1.
  - SET, state 1: toggle only; no state change.
  - RESET, state 0: t_set ≥ GAP0_RS.
  - RESET, state 1: shadow → 0; t_set ≥ GAP1_RS; t_clk ≥ GAP1_RC.
  - READ, state 1: t_reset ≥ GAP1_CR; t_clk ≥ GAP1_CC; shadow unchanged.
  - READ, state 0: toggle only; no timer loads.
- Timer loads take the maximum of the current value and the new value. They never shorten a pending block.
- Timers decrement by 1 per cycle, saturating at 0.

## Timing
- Gap semantics: if a command issues at edge k with gap G against target X, a command to X may issue no earlier than edge k+G. G=1 means back-to-back issue is allowed.
- Latency: a command accepted at edge k can toggle its line at edge k+1 at the earliest.
- Toggle outputs are registered; there is no combinational path from cmd_* to them.
- A blocked head stalls the whole FIFO (head-of-line blocking is intended). cmd_ready falls only when the FIFO is full.
- Timers load at the issue edge and begin counting on the next cycle.
- Reset mid-operation: pending commands are discarded and timers cleared. Toggle lines return to 0; a downstream cell sees this as an extra edge, so the cell must be reset alongside.
- ev_cnt wraps 255 → 0.

## Configuration
- `NDO_DRV_STATE_AWARE_EN` defined: gaps are applied according to shadow_state, per the issue rules.
- Macro undefined: worst-case spacing is applied regardless of shadow state.
  - Every SET/RESET loads t_set ≥ max(GAP0_RS, GAP1_RS) and t_clk ≥ GAP1_RC.
  - Every READ loads t_reset ≥ GAP1_CR and t_clk ≥ GAP1_CC.
  - shadow_state is still tracked and output.

## Test plan
- Reset, then SET, READ, READ pushed on consecutive cycles (macro on): set_t toggles at edge 1 and clk_t at edge 2, then again at edge 7; ev_cnt = 3, shadow = 1.
- From state 1, RESET then SET: reset_t toggles at edge k, set_t at k+2; shadow goes 1→0→1.
- From state 0, READ, READ: clk_t toggles at k and k+1 with no gaps (macro on). With the macro off, the second toggle is at k+5.
- Push 6 commands behind a blocked READ with DEPTH=4: cmd_ready drops after 4 entries, no command is lost, and issue order is preserved.
- Assert reset mid-stall with 3 queued and t_clk=4: the next cycle has all outputs 0, busy 0, and cmd_ready 1 after release.
- NOP between two SETs: ev_cnt advances by 2 only; the NOP consumes one issue cycle.
